// File: rtl/alu_issue.sv
// ALU issue stage: decodes instructions into ALU control bundles and buffers them in a 2-entry FIFO.
// Optional popped-illegal-entry counter enabled by defining ALU_ISSUE_ERR_EN.
module alu_issue #(
    parameter int OPERAND_WIDTH  = 16,
    parameter int NUM_OPERATIONS = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [4:0]                opcode,
    input  logic [1:0]                func,
    input  logic [OPERAND_WIDTH-1:0]  rs_data,
    input  logic [OPERAND_WIDTH-1:0]  rt_data,
    input  logic [OPERAND_WIDTH-1:0]  imm,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OPERAND_WIDTH-1:0]  InA,
    output logic [OPERAND_WIDTH-1:0]  InB,
    output logic [NUM_OPERATIONS-1:0] Oper,
    output logic                      Cin,
    output logic                      invA,
    output logic                      invB,
    output logic                      sign,
    output logic                      illegal
`ifdef ALU_ISSUE_ERR_EN
    ,
    output logic [7:0]                err_count
`endif
);

    typedef struct packed {
        logic [OPERAND_WIDTH-1:0]  a;
        logic [OPERAND_WIDTH-1:0]  b;
        logic [NUM_OPERATIONS-1:0] oper;
        logic                      cin;
        logic                      inva;
        logic                      invb;
        logic                      sgn;
        logic                      ill;
    } bundle_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    function automatic bundle_t decode(
        input logic [4:0]               op,
        input logic [1:0]               fn,
        input logic [OPERAND_WIDTH-1:0] rs,
        input logic [OPERAND_WIDTH-1:0] rt,
        input logic [OPERAND_WIDTH-1:0] im
    );
        bundle_t    d;
        logic       is_arith;
        logic       is_shift;
        logic [1:0] f;
        d        = '0;
        is_arith = 1'b0;
        is_shift = 1'b0;
        f        = fn;
        d.a      = rs;
        d.b      = rt;
        if (op == 5'b11011) begin
            is_arith = 1'b1;
        end else if (op == 5'b11010) begin
            is_shift = 1'b1;
        end else if (op[4:2] == 3'b010) begin
            is_arith = 1'b1;
            f        = op[1:0];
            d.b      = im;
        end else if (op[4:2] == 3'b101) begin
            is_shift = 1'b1;
            f        = op[1:0];
            d.b      = im;
        end else begin
            // Undecodable: behave as rs + 0 and flag it
            d.b    = '0;
            d.oper = NUM_OPERATIONS'(3'b100);
            d.sgn  = 1'b1;
            d.ill  = 1'b1;
        end
        if (is_arith) begin
            case (f)
                2'b00: begin
                    d.oper = NUM_OPERATIONS'(3'b100);
                    d.sgn  = 1'b1;
                end
                2'b01: begin
                    d.oper = NUM_OPERATIONS'(3'b100);
                    d.inva = 1'b1;
                    d.cin  = 1'b1;
                    d.sgn  = 1'b1;
                end
                2'b10: d.oper = NUM_OPERATIONS'(3'b111);
                2'b11: begin
                    d.oper = NUM_OPERATIONS'(3'b101);
                    d.invb = 1'b1;
                end
                default: d.oper = NUM_OPERATIONS'(3'b100);
            endcase
        end else if (is_shift) begin
            d.oper = NUM_OPERATIONS'({1'b0, f});
        end else begin
            d.cin = 1'b0;
        end
        return d;
    endfunction

    state_t  r_state;
    state_t  w_next_state;
    bundle_t r_ent0;
    bundle_t r_ent1;
    bundle_t w_next_ent0;
    bundle_t w_next_ent1;
    bundle_t w_dec;
    logic    r_in_ready;
    logic    r_out_valid;
    logic    w_push;
    logic    w_pop;

    assign w_dec  = decode(opcode, func, rs_data, rt_data, imm);
    assign w_push = in_valid && r_in_ready;
    assign w_pop  = r_out_valid && out_ready;

    // Occupancy, FIFO storage and registered handshake flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_ent0      <= '0;
            r_ent1      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_ent0      <= w_next_ent0;
            r_ent1      <= w_next_ent1;
            r_in_ready  <= (w_next_state != ST_TWO);
            r_out_valid <= (w_next_state != ST_EMPTY);
        end
    end

    // Next occupancy and entry contents; empty slots are kept zero so idle outputs read zero
    always_comb begin
        w_next_state = r_state;
        w_next_ent0  = r_ent0;
        w_next_ent1  = r_ent1;
        if (flush) begin
            w_next_state = ST_EMPTY;
            w_next_ent0  = '0;
            w_next_ent1  = '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        w_next_state = ST_ONE;
                        w_next_ent0  = w_dec;
                    end else begin
                        w_next_state = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        w_next_ent0 = w_dec;
                    end else if (w_push) begin
                        w_next_state = ST_TWO;
                        w_next_ent1  = w_dec;
                    end else if (w_pop) begin
                        w_next_state = ST_EMPTY;
                        w_next_ent0  = '0;
                    end else begin
                        w_next_state = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        w_next_state = ST_ONE;
                        w_next_ent0  = r_ent1;
                        w_next_ent1  = '0;
                    end else begin
                        w_next_state = ST_TWO;
                    end
                end
                default: begin
                    w_next_state = ST_EMPTY;
                    w_next_ent0  = '0;
                    w_next_ent1  = '0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign InA       = r_ent0.a;
    assign InB       = r_ent0.b;
    assign Oper      = r_ent0.oper;
    assign Cin       = r_ent0.cin;
    assign invA      = r_ent0.inva;
    assign invB      = r_ent0.invb;
    assign sign      = r_ent0.sgn;
    assign illegal   = r_ent0.ill;

`ifdef ALU_ISSUE_ERR_EN
    logic [7:0] r_err_count;

    // Saturating count of illegal entries actually consumed downstream
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= 8'd0;
        end else if (!flush && w_pop && r_ent0.ill && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end else begin
            r_err_count <= r_err_count;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have parameter OPERAND_WIDTH, default 16, datapath width.
REQ-002 The block SHALL have parameter NUM_OPERATIONS, default 3, width of Oper.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port in_valid  input  1  upstream instruction valid.
REQ-006 The block SHALL have port in_ready  output  1  block can accept an instruction.
REQ-007 The block SHALL have port opcode  input  5  instruction opcode.
REQ-008 The block SHALL have port func  input  2  R-type function field.
REQ-009 The block SHALL have ports rs_data, rt_data, imm  input  OPERAND_WIDTH  register operands and sign/zero-extended immediate.
REQ-010 The block SHALL have port flush  input  1  discard all buffered entries.
REQ-011 The block SHALL have port out_valid  output  1  ALU bundle valid.
REQ-012 The block SHALL have port out_ready  input  1  execute stage consumes bundle.
REQ-013 The block SHALL have ports InA, InB  output  OPERAND_WIDTH; Oper  output  NUM_OPERATIONS; Cin, invA, invB, sign  output  1 each; these drive the ALU directly.
REQ-014 The block SHALL have port illegal  output  1  buffered head entry had an undecodable opcode.

Function
REQ-015 Decode, 11011 (R-arith): func 00 ADD Oper=100; 01 SUB (rt-rs) Oper=100 invA=1 Cin=1; 10 XOR Oper=111; 11 ANDN Oper=101 invB=1; InA=rs_data, InB=rt_data.
REQ-016 Decode, 11010 (R-shift): Oper={0,func}, invA=invB=Cin=0, InA=rs_data, InB=rt_data.
REQ-017 Decode, 010xx (I-arith): same as REQ-015 with func=opcode[1:0] and InB=imm.
REQ-018 Decode, 101xx (I-shift): same as REQ-016 with func=opcode[1:0] and InB=imm.
REQ-019 sign SHALL be 1 for ADD/SUB forms, 0 otherwise; Cin/invA/invB SHALL be 0 unless listed.
REQ-020 Any other opcode SHALL decode as ADD of rs_data and 0 (InB=0) with illegal bit set.
REQ-021 Decoded bundle SHALL be stored in a 2-entry FIFO; state machine EMPTY/ONE/TWO by occupancy.
REQ-022 Push when in_valid&&in_ready; pop when out_valid&&out_ready; simultaneous push+pop keeps occupancy and order.
REQ-023 in_ready SHALL be a registered output: 1 in EMPTY/ONE, 0 in TWO.
REQ-024 out_valid SHALL be 1 in ONE/TWO; outputs SHALL show the oldest entry and hold stable while out_valid&&!out_ready.
REQ-025 Latency: instruction accepted in cycle N SHALL appear on outputs in cycle N+1 when FIFO was EMPTY.
REQ-026 Push in TWO SHALL not occur (in_ready=0); pop in EMPTY SHALL not occur.
REQ-027 flush SHALL force EMPTY next cycle, dropping any same-cycle push; flush has priority over push/pop.
REQ-028 Outputs when out_valid=0 SHALL be all-zero.

Reset
REQ-029 rst SHALL force EMPTY, out_valid=0, in_ready=1 next cycle, all bundle outputs and illegal=0.
REQ-030 rst SHALL have priority over flush, push and pop; reset mid-transfer discards the entry.

Configuration
REQ-031 Macro ALU_ISSUE_ERR_EN: when defined, port err_count output 8 SHALL count popped illegal entries, saturating at 255, cleared by rst only.
REQ-032 Without ALU_ISSUE_ERR_EN, err_count port and counter SHALL be absent; illegal output still exists.

Verification
REQ-033 Reset then opcode 11011 func 01, rs=0x0003, rt=0x0010, out_ready=1 -> next cycle out_valid=1, Oper=100, invA=1, Cin=1, sign=1, InA=0x0003, InB=0x0010.
REQ-034 out_ready=0, push 3 ops back-to-back -> in_ready drops after 2nd accept; 3rd held; outputs stay on 1st op.
REQ-035 TWO state, in_valid=1 and out_ready=1 same cycle -> occupancy stays TWO only if push allowed; in ONE with push+pop, order preserved (ops A,B popped in order).
REQ-036 Opcode 10101 imm=0x0004 -> Oper=001, InB=0x0004, sign=0.
REQ-037 Opcode 00000 -> illegal=1, Oper=100, InB=0; with ALU_ISSUE_ERR_EN err_count increments to 1 on pop.
REQ-038 flush asserted with occupancy TWO and concurrent push -> next cycle out_valid=0, in_ready=1.
